toaplan2_snd_mailbox: RTL and testbench
=======================================

Name: toaplan2_snd_mailbox

Overview:
Parametrised main-CPU to sound-CPU command mailbox. It replaces the single SOUNDLATCH/Z80_SND_CMD/Z80_SND_CMD_ACK latch with NUM_CH independent command FIFOs and one reply latch running back from the sound CPU. It sits between the 68k bus decoder and the Z80 I/O decoder inside a game's sound subsystem. It adds queueing, overflow tracking, a selectable full policy and IRQ generation to the sound CPU.

Parameters:
NUM_CH, 2, number of command channels (1..4)
DEPTH, 4, entries per channel FIFO; power of two, 1..16; DEPTH=1 gives plain-latch behaviour
DW, 8, command/reply data width
OVERWRITE, 0, full-FIFO policy: 0 = drop new write, 1 = replace newest entry
IRQ_PULSE, 0, 0 = level IRQ, 1 = one-cycle pulse per empty-to-nonempty transition

Ports:
CLK  in  1  system clock (48 MHz domain)
RESET_N  in  1  asynchronous active-low reset
MAIN_WR  in  1  main CPU write strobe, one cycle per access
MAIN_CH  in  max(1,clog2(NUM_CH))  target channel for MAIN_WR
MAIN_DIN  in  DW  command data
MAIN_FULL  out  NUM_CH  per-channel full flag
MAIN_OVF  out  NUM_CH  sticky per-channel overflow flag
MAIN_REPLY_DOUT  out  DW  reply latch contents
MAIN_REPLY_VALID  out  1  reply latch holds unread data
MAIN_REPLY_RD  in  1  main CPU consumes reply
SND_RD  in  1  sound CPU pop strobe
SND_CH  in  max(1,clog2(NUM_CH))  channel to pop
SND_DOUT  out  DW  popped data, registered
SND_PENDING  out  NUM_CH  channel non-empty
SND_IRQ_EN  in  NUM_CH  per-channel IRQ mask
SND_IRQ  out  1  interrupt to sound CPU
SND_WR  in  1  sound CPU writes reply
SND_REPLY_DIN  in  DW  reply data
FLUSH  in  1  synchronous clear (game reset/pause)

Behaviour:
- Reset (RESET_N low, async): all counts, read/write pointers, MAIN_OVF, MAIN_REPLY_VALID, SND_DOUT, MAIN_REPLY_DOUT and SND_IRQ go to 0. MAIN_FULL is 0. FIFO storage is not cleared. Reset asserted mid-transfer aborts the transfer with no partial state kept.
- Per channel: count width clog2(DEPTH+1). wptr and rptr are clog2(DEPTH) bits (minimum 1) and wrap modulo DEPTH.
- Push: on MAIN_WR with MAIN_CH<NUM_CH, accepted if count<DEPTH, or if a pop of the same channel happens in the same cycle. Accepted push writes storage[wptr], then wptr+1 and count+1.
- Full, no same-cycle pop:
  - OVERWRITE=0: data is dropped and MAIN_OVF[ch] is set.
  - OVERWRITE=1: storage[wptr-1] is overwritten, count is unchanged, and MAIN_OVF[ch] is set.
- MAIN_CH>=NUM_CH: the write is ignored and no flag changes.
- Pop: on SND_RD with count>0, SND_DOUT <= storage[rptr] on the next CLK edge (latency 1), then rptr+1 and count-1.
- Pop on an empty channel: SND_DOUT holds its previous value and no state changes. There is no bypass: a write and a read to an empty channel in the same cycle push only, and SND_DOUT keeps its old value.
- Push and pop on the same channel in the same cycle: both occur and count is unchanged.
- MAIN_FULL[ch] = (count==DEPTH). SND_PENDING[ch] = (count!=0). Both are registered, reflecting the post-edge count.
- MAIN_OVF[ch] clears only on FLUSH or reset.
- SND_IRQ:
  - IRQ_PULSE=0: SND_IRQ = |(SND_PENDING & SND_IRQ_EN), registered.
  - IRQ_PULSE=1: one-cycle high when any enabled channel goes count 0 -> nonzero. Simultaneous transitions on several channels give a single pulse.
- Reply latch: SND_WR loads MAIN_REPLY_DOUT and sets MAIN_REPLY_VALID. MAIN_REPLY_RD clears VALID. If both occur in the same cycle, set wins and the new data is loaded. SND_WR while VALID overwrites without any flag.
- FLUSH: in the next cycle counts, pointers, OVF and REPLY_VALID are 0. Data registers are unchanged. FLUSH has priority over push and pop in the same cycle.

Decomposition:
- Shared package toaplan2_snd_pkg holds:
  - CH_W function: max(1,clog2(n)).
  - Localparams for the default NUM_CH/DEPTH used by Tekipaki/Whoopee (1 channel, DEPTH 1) and by later multi-latch boards (2, 4).
- Natural sub-module: toaplan2_snd_fifo, a single-channel FIFO with push/pop/full/empty/ovf and the OVERWRITE policy, instantiated NUM_CH times via generate.
- The top level holds channel decode, IRQ logic and the reply latch.

Test Plan:
- Reset then 3 pushes 0x11,0x22,0x33 to ch0 -> SND_PENDING=01, count 3. Three pops give SND_DOUT 0x11,0x22,0x33, each valid 1 cycle after SND_RD. PENDING returns to 00.
- DEPTH=4, OVERWRITE=0: 5 pushes 0xA0..0xA4 -> MAIN_FULL[0]=1, MAIN_OVF[0]=1, pops return A0..A3. Rerun with OVERWRITE=1 -> pops return A0,A1,A2,A4.
- Full ch1 with simultaneous push 0x55 and pop -> pop returns the oldest entry, 0x55 is accepted, count stays 4, and OVF is not set.
- IRQ_PULSE=1, SND_IRQ_EN=11: push ch0 and ch1 in the same cycle -> exactly one SND_IRQ pulse. With IRQ_PULSE=0 -> SND_IRQ stays high until both channels are drained.
- SND_WR 0x7E coincident with MAIN_REPLY_RD -> VALID=1, DOUT=0x7E. A lone MAIN_REPLY_RD then gives VALID=0.
- Async RESET_N pulse mid-pop, and FLUSH together with a push -> all flags 0 and no entry accepted. SND_DOUT is 0 after reset and unchanged after FLUSH.

Source files
------------

// File: rtl/toaplan2_snd_pkg.sv
`default_nettype none
// ==========================================================================
// toaplan2_snd_pkg - shared helpers and board presets for the sound mailbox
// Revision 1.0 - initial release
// ==========================================================================
package toaplan2_snd_pkg;

   // Tekipaki/Whoopee use a single plain latch; later boards use two queued channels
   localparam int c_TEKIPAKI_NUM_CH = 1;
   localparam int c_TEKIPAKI_DEPTH  = 1;
   localparam int c_MULTI_NUM_CH    = 2;
   localparam int c_MULTI_DEPTH     = 4;

   function automatic int CH_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/toaplan2_snd_fifo.sv
`default_nettype none
// ==========================================================================
// toaplan2_snd_fifo - single-channel command FIFO with drop/replace full policy
// Revision 1.0 - initial release
// ==========================================================================
module toaplan2_snd_fifo
   import toaplan2_snd_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int DW        = 8,
   parameter bit OVERWRITE = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic [DW-1:0] i_din,
   input  logic          i_pop,
   output logic [DW-1:0] o_rd_data,
   output logic          o_pop_ok,
   output logic          o_full,
   output logic          o_pending,
   output logic          o_pending_next,
   output logic          o_ovf
);

   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam int c_PTR_W = CH_W(DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

   logic [DW-1:0]      mem_q [DEPTH];
   logic [c_CNT_W-1:0] count_q, count_d;
   logic [c_PTR_W-1:0] wptr_q, wptr_d;
   logic [c_PTR_W-1:0] rptr_q, rptr_d;
   logic               ovf_q, ovf_d;
   logic               w_full, w_pop_ok, w_push_ok, w_overflow, w_mem_we;
   logic [c_PTR_W-1:0] w_wlast, w_mem_addr;

   function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_LAST) ? '0 : p + c_PTR_ONE;
   endfunction

   always_comb begin
      w_full     = (count_q == c_CNT_FULL);
      w_pop_ok   = i_pop && !i_flush && (count_q != '0);
      // a same-cycle pop frees the slot, so a full FIFO still accepts the push
      w_push_ok  = i_push && !i_flush && (!w_full || w_pop_ok);
      w_overflow = i_push && !i_flush && w_full && !w_pop_ok;
      w_wlast    = (wptr_q == '0) ? c_PTR_LAST : wptr_q - c_PTR_ONE;

      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      ovf_d   = ovf_q;
      if (i_flush) begin
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
         ovf_d   = 1'b0;
      end else begin
         if (w_push_ok) wptr_d = ptr_inc(wptr_q);
         if (w_pop_ok)  rptr_d = ptr_inc(rptr_q);
         if (w_push_ok && !w_pop_ok)      count_d = count_q + c_CNT_ONE;
         else if (!w_push_ok && w_pop_ok) count_d = count_q - c_CNT_ONE;
         if (w_overflow) ovf_d = 1'b1;
      end

      w_mem_we   = w_push_ok || (w_overflow && OVERWRITE);
      w_mem_addr = w_push_ok ? wptr_q : w_wlast;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) mem_q[w_mem_addr] <= i_din;
   end

   assign o_rd_data      = mem_q[rptr_q];
   assign o_pop_ok       = w_pop_ok;
   assign o_full         = w_full;
   assign o_pending      = (count_q != '0);
   assign o_pending_next = (count_d != '0);
   assign o_ovf          = ovf_q;

endmodule
`default_nettype wire

// File: rtl/toaplan2_snd_mailbox.sv
`default_nettype none
// ==========================================================================
// toaplan2_snd_mailbox - main-to-sound CPU command FIFOs, sound IRQ and reply latch
// Revision 1.0 - initial release
// ==========================================================================
module toaplan2_snd_mailbox
   import toaplan2_snd_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DEPTH     = 4,
   parameter int DW        = 8,
   parameter bit OVERWRITE = 1'b0,
   parameter bit IRQ_PULSE = 1'b0
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic                      MAIN_WR,
   input  logic [CH_W(NUM_CH)-1:0]   MAIN_CH,
   input  logic [DW-1:0]             MAIN_DIN,
   output logic [NUM_CH-1:0]         MAIN_FULL,
   output logic [NUM_CH-1:0]         MAIN_OVF,
   output logic [DW-1:0]             MAIN_REPLY_DOUT,
   output logic                      MAIN_REPLY_VALID,
   input  logic                      MAIN_REPLY_RD,
   input  logic                      SND_RD,
   input  logic [CH_W(NUM_CH)-1:0]   SND_CH,
   output logic [DW-1:0]             SND_DOUT,
   output logic [NUM_CH-1:0]         SND_PENDING,
   input  logic [NUM_CH-1:0]         SND_IRQ_EN,
   output logic                      SND_IRQ,
   input  logic                      SND_WR,
   input  logic [DW-1:0]             SND_REPLY_DIN,
   input  logic                      FLUSH
);

   localparam int c_CHW = CH_W(NUM_CH);

   logic [NUM_CH-1:0] w_push, w_pop, w_pop_ok, w_pend_next;
   logic [DW-1:0]     w_rd_data [NUM_CH];

   logic [DW-1:0] snd_dout_q, snd_dout_d;
   logic [DW-1:0] reply_dout_q, reply_dout_d;
   logic          reply_valid_q, reply_valid_d;
   logic          snd_irq_q, snd_irq_d;

   // Out-of-range channel numbers never match a decode term and are dropped
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_push[g] = MAIN_WR && (MAIN_CH == c_CHW'(g));
      assign w_pop[g]  = SND_RD && (SND_CH == c_CHW'(g));

      toaplan2_snd_fifo #(
         .DEPTH     (DEPTH),
         .DW        (DW),
         .OVERWRITE (OVERWRITE)
      ) u_fifo (
         .clk            (CLK),
         .rst_n          (RESET_N),
         .i_flush        (FLUSH),
         .i_push         (w_push[g]),
         .i_din          (MAIN_DIN),
         .i_pop          (w_pop[g]),
         .o_rd_data      (w_rd_data[g]),
         .o_pop_ok       (w_pop_ok[g]),
         .o_full         (MAIN_FULL[g]),
         .o_pending      (SND_PENDING[g]),
         .o_pending_next (w_pend_next[g]),
         .o_ovf          (MAIN_OVF[g])
      );
   end

   always_comb begin
      snd_dout_d = snd_dout_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_pop_ok[i]) snd_dout_d = w_rd_data[i];
      end

      // Pulse mode fires on empty-to-nonempty; several channels at once still give one pulse
      if (IRQ_PULSE) snd_irq_d = |(w_pend_next & ~SND_PENDING & SND_IRQ_EN);
      else           snd_irq_d = |(w_pend_next & SND_IRQ_EN);

      reply_dout_d  = reply_dout_q;
      reply_valid_d = reply_valid_q;
      if (FLUSH) begin
         reply_valid_d = 1'b0;
      end else if (SND_WR) begin
         reply_dout_d  = SND_REPLY_DIN;
         reply_valid_d = 1'b1;
      end else if (MAIN_REPLY_RD) begin
         reply_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         snd_dout_q    <= '0;
         reply_dout_q  <= '0;
         reply_valid_q <= 1'b0;
         snd_irq_q     <= 1'b0;
      end else begin
         snd_dout_q    <= snd_dout_d;
         reply_dout_q  <= reply_dout_d;
         reply_valid_q <= reply_valid_d;
         snd_irq_q     <= snd_irq_d;
      end
   end

   assign SND_DOUT         = snd_dout_q;
   assign MAIN_REPLY_DOUT  = reply_dout_q;
   assign MAIN_REPLY_VALID = reply_valid_q;
   assign SND_IRQ          = snd_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_toaplan2_snd_mailbox.sv
`default_nettype none
// ==========================================================================
// tb_toaplan2_snd_mailbox - drop/level and replace/pulse mailboxes vs a queue model
// Revision 1.0 - initial release
// ==========================================================================
module tb_toaplan2_snd_mailbox;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       main_wr = 1'b0;
   logic [0:0] main_ch = '0;
   logic [7:0] main_din = '0;
   logic       main_reply_rd = 1'b0;
   logic       snd_rd = 1'b0;
   logic [0:0] snd_ch = '0;
   logic [1:0] irq_en = '0;
   logic       snd_wr = 1'b0;
   logic [7:0] snd_reply_din = '0;
   logic       flush = 1'b0;

   logic [1:0] full [2];
   logic [1:0] ovf  [2];
   logic [1:0] pend [2];
   logic [7:0] rdout [2];
   logic [7:0] sdout [2];
   logic       rvalid [2];
   logic       irq [2];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // dut0: drop-on-full with level IRQ; dut1: replace-newest with pulse IRQ
   toaplan2_snd_mailbox #(.NUM_CH(2), .DEPTH(4), .DW(8), .OVERWRITE(1'b0), .IRQ_PULSE(1'b0)) u_dut0 (
      .CLK(clk), .RESET_N(rst_n), .MAIN_WR(main_wr), .MAIN_CH(main_ch), .MAIN_DIN(main_din),
      .MAIN_FULL(full[0]), .MAIN_OVF(ovf[0]), .MAIN_REPLY_DOUT(rdout[0]), .MAIN_REPLY_VALID(rvalid[0]),
      .MAIN_REPLY_RD(main_reply_rd), .SND_RD(snd_rd), .SND_CH(snd_ch), .SND_DOUT(sdout[0]),
      .SND_PENDING(pend[0]), .SND_IRQ_EN(irq_en), .SND_IRQ(irq[0]), .SND_WR(snd_wr),
      .SND_REPLY_DIN(snd_reply_din), .FLUSH(flush));

   toaplan2_snd_mailbox #(.NUM_CH(2), .DEPTH(4), .DW(8), .OVERWRITE(1'b1), .IRQ_PULSE(1'b1)) u_dut1 (
      .CLK(clk), .RESET_N(rst_n), .MAIN_WR(main_wr), .MAIN_CH(main_ch), .MAIN_DIN(main_din),
      .MAIN_FULL(full[1]), .MAIN_OVF(ovf[1]), .MAIN_REPLY_DOUT(rdout[1]), .MAIN_REPLY_VALID(rvalid[1]),
      .MAIN_REPLY_RD(main_reply_rd), .SND_RD(snd_rd), .SND_CH(snd_ch), .SND_DOUT(sdout[1]),
      .SND_PENDING(pend[1]), .SND_IRQ_EN(irq_en), .SND_IRQ(irq[1]), .SND_WR(snd_wr),
      .SND_REPLY_DIN(snd_reply_din), .FLUSH(flush));

   // ---------------- behavioural model: one queue per (dut, channel) ----------------
   logic [7:0] mq [4][$];
   logic [1:0] m_ovf [2];
   logic [7:0] m_sdout [2];
   logic [7:0] m_rdout [2];
   logic       m_rvalid [2];
   logic       m_irq [2];
   bit         m_live = 1'b0;

   task automatic model_step(input int k);
      int  pre [2];
      bit  pulse;
      int  wi;
      pulse = (k == 1);
      if (flush) begin
         mq[k*2].delete();
         mq[k*2+1].delete();
         m_ovf[k]    = '0;
         m_rvalid[k] = 1'b0;
         m_irq[k]    = 1'b0;
         return;
      end
      for (int c = 0; c < 2; c++) pre[c] = mq[k*2+c].size();
      if (snd_rd && mq[k*2+int'(snd_ch)].size() > 0)
         m_sdout[k] = mq[k*2+int'(snd_ch)].pop_front();
      if (main_wr) begin
         wi = k*2 + int'(main_ch);
         if (mq[wi].size() < 4) begin
            mq[wi].push_back(main_din);
         end else begin
            m_ovf[k][main_ch] = 1'b1;
            if (k == 1) mq[wi][3] = main_din;
         end
      end
      if (snd_wr) begin
         m_rdout[k]  = snd_reply_din;
         m_rvalid[k] = 1'b1;
      end else if (main_reply_rd) begin
         m_rvalid[k] = 1'b0;
      end
      m_irq[k] = 1'b0;
      for (int c = 0; c < 2; c++)
         if (irq_en[c] && mq[k*2+c].size() > 0 && (!pulse || pre[c] == 0)) m_irq[k] = 1'b1;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mq[i].delete();
         for (int k = 0; k < 2; k++) begin
            m_ovf[k] = '0; m_sdout[k] = '0; m_rdout[k] = '0;
            m_rvalid[k] = 1'b0; m_irq[k] = 1'b0;
         end
         m_live = 1'b1;
      end else begin
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, on the falling edge
   initial forever begin
      @(negedge clk);
      if (m_live) begin
         for (int k = 0; k < 2; k++) begin
            chk("m_full", k, {6'd0, full[k]}, {6'd0, mq[k*2+1].size() == 4, mq[k*2].size() == 4});
            chk("m_pend", k, {6'd0, pend[k]}, {6'd0, mq[k*2+1].size() != 0, mq[k*2].size() != 0});
            chk("m_ovf", k, {6'd0, ovf[k]}, {6'd0, m_ovf[k]});
            chk("m_sdout", k, sdout[k], m_sdout[k]);
            chk("m_rdout", k, rdout[k], m_rdout[k]);
            chk("m_rvalid", k, {7'd0, rvalid[k]}, {7'd0, m_rvalid[k]});
            chk("m_irq", k, {7'd0, irq[k]}, {7'd0, m_irq[k]});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [0:0] c, input logic [7:0] d);
      main_wr = 1'b1; main_ch = c; main_din = d;
      step();
      main_wr = 1'b0;
   endtask

   task automatic pop(input logic [0:0] c);
      snd_rd = 1'b1; snd_ch = c;
      step();
      snd_rd = 1'b0;
   endtask

   task automatic push_pop(input logic [0:0] c, input logic [7:0] d);
      main_wr = 1'b1; main_ch = c; main_din = d;
      snd_rd = 1'b1; snd_ch = c;
      step();
      main_wr = 1'b0; snd_rd = 1'b0;
   endtask

   logic [7:0] exp_drop [4];
   logic [7:0] exp_repl [4];

   initial begin
      exp_drop = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      exp_repl = '{8'hA0, 8'hA1, 8'hA2, 8'hA4};

      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("rst_sdout", 0, sdout[0], 8'h00);
      chk("rst_pend", 0, {6'd0, pend[0]}, 8'h00);
      chk("rst_full", 1, {6'd0, full[1]}, 8'h00);
      chk("rst_rvalid", 1, {7'd0, rvalid[1]}, 8'h00);

      // basic ordering and 1-cycle pop latency
      push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
      chk("pend_3", 0, {6'd0, pend[0]}, 8'h01);
      pop(0); chk("pop_11", 0, sdout[0], 8'h11);
      pop(0); chk("pop_22", 0, sdout[0], 8'h22);
      pop(0); chk("pop_33", 0, sdout[0], 8'h33);
      chk("pend_0", 0, {6'd0, pend[0]}, 8'h00);

      // overflow: drop vs replace-newest
      for (int i = 0; i < 5; i++) push(0, 8'hA0 + 8'(i));
      for (int k = 0; k < 2; k++) begin
         chk("ovf_full", k, {6'd0, full[k]}, 8'h01);
         chk("ovf_flag", k, {6'd0, ovf[k]}, 8'h01);
      end
      for (int i = 0; i < 4; i++) begin
         pop(0);
         chk("drop_pop", 0, sdout[0], exp_drop[i]);
         chk("repl_pop", 1, sdout[1], exp_repl[i]);
      end

      // full channel with simultaneous push and pop
      for (int i = 0; i < 4; i++) push(1, 8'hB0 + 8'(i));
      push_pop(1, 8'h55);
      for (int k = 0; k < 2; k++) begin
         chk("pp_dout", k, sdout[k], 8'hB0);
         chk("pp_full", k, {6'd0, full[k]}, 8'h02);
         chk("pp_ovf", k, {6'd0, ovf[k]}, 8'h01);
      end
      repeat (4) pop(1);
      chk("pp_last", 0, sdout[0], 8'h55);

      flush = 1'b1; step(); flush = 1'b0;
      chk("flush_ovf", 0, {6'd0, ovf[0]}, 8'h00);
      chk("flush_ovf", 1, {6'd0, ovf[1]}, 8'h00);

      // IRQ: level on dut0, pulse per empty-to-nonempty on dut1
      irq_en = 2'b11;
      push(0, 8'hC0);
      chk("irq_lvl_a", 0, {7'd0, irq[0]}, 8'h01);
      chk("irq_pls_a", 1, {7'd0, irq[1]}, 8'h01);
      push(1, 8'hC1);
      chk("irq_pls_b", 1, {7'd0, irq[1]}, 8'h01);
      step();
      chk("irq_pls_end", 1, {7'd0, irq[1]}, 8'h00);
      chk("irq_lvl_hold", 0, {7'd0, irq[0]}, 8'h01);
      pop(0);
      chk("irq_lvl_one", 0, {7'd0, irq[0]}, 8'h01);
      pop(1);
      chk("irq_lvl_drained", 0, {7'd0, irq[0]}, 8'h00);
      irq_en = 2'b10;
      push(0, 8'hD0);
      chk("irq_mask_lvl", 0, {7'd0, irq[0]}, 8'h00);
      chk("irq_mask_pls", 1, {7'd0, irq[1]}, 8'h00);
      pop(0);
      irq_en = 2'b00;

      // reply latch: set wins over read, read clears, write overwrites
      snd_wr = 1'b1; snd_reply_din = 8'h7E; main_reply_rd = 1'b1;
      step();
      snd_wr = 1'b0; main_reply_rd = 1'b0;
      chk("rep_valid", 0, {7'd0, rvalid[0]}, 8'h01);
      chk("rep_dout", 0, rdout[0], 8'h7E);
      main_reply_rd = 1'b1; step(); main_reply_rd = 1'b0;
      chk("rep_clr", 0, {7'd0, rvalid[0]}, 8'h00);
      snd_wr = 1'b1; snd_reply_din = 8'h12; step();
      snd_reply_din = 8'h34; step();
      snd_wr = 1'b0;
      chk("rep_ovr", 1, rdout[1], 8'h34);

      // push and pop on an empty channel: push only, no bypass
      push_pop(0, 8'h66);
      chk("nobyp_dout", 0, sdout[0], 8'hD0);
      chk("nobyp_pend", 0, {6'd0, pend[0]}, 8'h01);
      pop(0);
      chk("nobyp_pop", 0, sdout[0], 8'h66);

      // flush beats a coincident push; data registers untouched
      snd_wr = 1'b1; snd_reply_din = 8'h5A; step(); snd_wr = 1'b0;
      flush = 1'b1; main_wr = 1'b1; main_ch = 1'b0; main_din = 8'h77;
      step();
      flush = 1'b0; main_wr = 1'b0;
      chk("fl_pend", 0, {6'd0, pend[0]}, 8'h00);
      chk("fl_rvalid", 0, {7'd0, rvalid[0]}, 8'h00);
      chk("fl_sdout", 0, sdout[0], 8'h66);
      chk("fl_rdout", 1, rdout[1], 8'h5A);

      // asynchronous reset in the middle of a pop
      push(0, 8'h99);
      snd_rd = 1'b1; snd_ch = 1'b0;
      #2 rst_n = 1'b0;
      #1 snd_rd = 1'b0;
      chk("arst_sdout", 0, sdout[0], 8'h00);
      chk("arst_pend", 1, {6'd0, pend[1]}, 8'h00);
      chk("arst_rdout", 0, rdout[0], 8'h00);
      step();
      rst_n = 1'b1;
      step();
      chk("arst_after", 1, sdout[1], 8'h00);
      chk("arst_pend2", 0, {6'd0, pend[0]}, 8'h00);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
